wb_arbiter: RTL and testbench

//  Write-back side of g_register: the writer feeding wb_i/wb_r_i/result_i.
//  - Collects results from two producers (ALU, MEM) through a small FIFO each.
//  - Round-robin arbitration picks one entry per cycle.
//  - Drives one registered write-back per cycle; that write also clears the

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_arbiter_fifo.sv | 63 ++++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, source encoding and FIFO entry layout for the write-back arbiter.
package wb_arbiter_pkg;

  localparam int unsigned W_RD  = 5;
  localparam int unsigned W_OPR = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [W_RD-1:0]  rd;
    logic [W_OPR-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Small FIFO holding pending write-backs from one producer.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_D = 2,
  parameter int unsigned FIFO_A = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  wb_entry_t       din_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [FIFO_A:0] count_o,
  output wb_entry_t       head_o
);

  localparam logic [FIFO_A:0] CNT_FULL = (FIFO_A+1)'(FIFO_D);

  wb_entry_t         mem_q [FIFO_D];
  logic [FIFO_A-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_A-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_A:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer/count next state; pointers wrap naturally since depth is a power of 2.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + FIFO_A'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_A'(1);
    if (do_push && !do_pop)      count_d = count_q + (FIFO_A+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (FIFO_A+1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: two producer FIFOs, round-robin pick, registered write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_D = 2,
  parameter int unsigned FIFO_A = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_v_i,
  output logic             alu_rdy_o,
  input  logic [W_RD-1:0]  alu_rd_i,
  input  logic [W_OPR-1:0] alu_data_i,
  input  logic             mem_v_i,
  output logic             mem_rdy_o,
  input  logic [W_RD-1:0]  mem_rd_i,
  input  logic [W_OPR-1:0] mem_data_i,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [W_OPR-1:0] result_o,
  output logic             idle_o
);

  wb_entry_t        alu_in, mem_in, alu_head, mem_head;
  logic             alu_full, alu_empty, mem_full, mem_empty;
  logic [FIFO_A:0]  alu_cnt, mem_cnt;
  logic             alu_pop, mem_pop;
  logic             gnt_v;
  src_e             gnt_src;
  src_e             rr_last_q, rr_last_d;
  logic             wb_q, wb_d;
  logic [W_RD-1:0]  wb_r_q, wb_r_d;
  logic [W_OPR-1:0] result_q, result_d;

  assign alu_in    = '{rd: alu_rd_i, data: alu_data_i};
  assign mem_in    = '{rd: mem_rd_i, data: mem_data_i};
  // Ready comes only from registered occupancy: no valid-to-ready path.
  assign alu_rdy_o = !alu_full;
  assign mem_rdy_o = !mem_full;

  wb_fifo #(.FIFO_D(FIFO_D), .FIFO_A(FIFO_A)) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (alu_v_i && alu_rdy_o),
    .pop_i   (alu_pop),
    .din_i   (alu_in),
    .full_o  (alu_full),
    .empty_o (alu_empty),
    .count_o (alu_cnt),
    .head_o  (alu_head)
  );

  wb_fifo #(.FIFO_D(FIFO_D), .FIFO_A(FIFO_A)) u_mem_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (mem_v_i && mem_rdy_o),
    .pop_i   (mem_pop),
    .din_i   (mem_in),
    .full_o  (mem_full),
    .empty_o (mem_empty),
    .count_o (mem_cnt),
    .head_o  (mem_head)
  );

  // Round-robin grant on FIFO heads and next write-back values.
  always_comb begin
    gnt_v     = 1'b0;
    gnt_src   = SRC_ALU;
    rr_last_d = rr_last_q;
    alu_pop   = 1'b0;
    mem_pop   = 1'b0;
    wb_d      = 1'b0;
    wb_r_d    = wb_r_q;
    result_d  = result_q;
    if (!alu_empty && !mem_empty) begin
      gnt_v   = 1'b1;
      gnt_src = (rr_last_q == SRC_MEM) ? SRC_ALU : SRC_MEM;
    end else if (!alu_empty) begin
      gnt_v   = 1'b1;
      gnt_src = SRC_ALU;
    end else if (!mem_empty) begin
      gnt_v   = 1'b1;
      gnt_src = SRC_MEM;
    end
    if (gnt_v) begin
      rr_last_d = gnt_src;
      wb_d      = 1'b1;
      if (gnt_src == SRC_ALU) begin
        alu_pop  = 1'b1;
        wb_r_d   = alu_head.rd;
        result_d = alu_head.data;
      end else begin
        mem_pop  = 1'b1;
        wb_r_d   = mem_head.rd;
        result_d = mem_head.data;
      end
    end
  end

  // Output register and round-robin history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= SRC_MEM;
      wb_q      <= 1'b0;
      wb_r_q    <= '0;
      result_q  <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      wb_q      <= wb_d;
      wb_r_q    <= wb_r_d;
      result_q  <= result_d;
    end
  end

  assign wb_o     = wb_q;
  assign wb_r_o   = wb_r_q;
  assign result_o = result_q;
  assign idle_o   = (alu_cnt == '0) && (mem_cnt == '0) && !wb_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-source write-back scoreboard.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned FIFO_D = 2;
  localparam int unsigned FIFO_A = 1;

  typedef logic [W_RD+W_OPR-1:0] ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             alu_v_i = 1'b0, mem_v_i = 1'b0;
  logic             alu_rdy_o, mem_rdy_o;
  logic [W_RD-1:0]  alu_rd_i = '0, mem_rd_i = '0;
  logic [W_OPR-1:0] alu_data_i = '0, mem_data_i = '0;
  logic             wb_o, idle_o;
  logic [W_RD-1:0]  wb_r_o;
  logic [W_OPR-1:0] result_o;

  ent_t alu_q[$];
  ent_t mem_q[$];
  int   wb_src[$];
  int   wb_cyc[$];
  int   total = 0, bad = 0, cyc = 0;
  int   alu_acc = 0, mem_acc = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_D(FIFO_D), .FIFO_A(FIFO_A)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_v_i    (alu_v_i),
    .alu_rdy_o  (alu_rdy_o),
    .alu_rd_i   (alu_rd_i),
    .alu_data_i (alu_data_i),
    .mem_v_i    (mem_v_i),
    .mem_rdy_o  (mem_rdy_o),
    .mem_rd_i   (mem_rd_i),
    .mem_data_i (mem_data_i),
    .wb_o       (wb_o),
    .wb_r_o     (wb_r_o),
    .result_o   (result_o),
    .idle_o     (idle_o)
  );

  always @(posedge clk) cyc++;

  // Scoreboard: each write-back must equal the head of one source's queue.
  always @(negedge clk) begin
    ent_t got;
    int   src;
    if (rst && wb_o) begin
      got = {wb_r_o, result_o};
      src = 2;
      if (alu_q.size() > 0 && got == alu_q[0]) begin
        void'(alu_q.pop_front());
        src = 0;
      end else if (mem_q.size() > 0 && got == mem_q[0]) begin
        void'(mem_q.pop_front());
        src = 1;
      end
      total++;
      assert (src != 2) else begin
        bad++;
        $error("FAIL sb_match: observed rd=%0d data=%h, required alu_head=%h or mem_head=%h",
               wb_r_o, result_o, (alu_q.size() > 0) ? alu_q[0] : '0,
               (mem_q.size() > 0) ? mem_q[0] : '0);
      end
      wb_src.push_back(src);
      wb_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
    end
  endtask

  // One clock: record what gets accepted at the coming edge, then step past it.
  task automatic cycle(output bit a_acc, output bit m_acc);
    a_acc = alu_v_i && alu_rdy_o;
    m_acc = mem_v_i && mem_rdy_o;
    if (a_acc) begin alu_q.push_back({alu_rd_i, alu_data_i}); alu_acc++; end
    if (m_acc) begin mem_q.push_back({mem_rd_i, mem_data_i}); mem_acc++; end
    @(posedge clk); #1;
  endtask

  task automatic step();
    bit a, m;
    cycle(a, m);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    alu_v_i = 1'b0;
    mem_v_i = 1'b0;
    alu_q.delete();
    mem_q.delete();
    wb_src.delete();
    wb_cyc.delete();
    alu_acc = 0;
    mem_acc = 0;
    #1;
    chk({tag, "_async_wb"}, 64'(wb_o), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_alu_rdy"}, 64'(alu_rdy_o), 64'(1));
    chk({tag, "_mem_rdy"}, 64'(mem_rdy_o), 64'(1));
    chk({tag, "_idle"}, 64'(idle_o), 64'(1));
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(idle_o && alu_q.size() == 0 && mem_q.size() == 0) && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 64'(idle_o), 64'(1));
  endtask

  initial begin
    bit a, m;
    int n_a, n_m, alt_err, k;

    // Reset state
    @(posedge clk); #1;
    chk("rst_wb", 64'(wb_o), 64'(0));
    chk("rst_wb_r", 64'(wb_r_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));
    chk("rst_idle", 64'(idle_o), 64'(1));
    chk("rst_alu_rdy", 64'(alu_rdy_o), 64'(1));
    chk("rst_mem_rdy", 64'(mem_rdy_o), 64'(1));
    rst = 1'b1;

    // Single ALU push: two-cycle latency, one-cycle strobe, values hold after
    alu_rd_i = 5'd3; alu_data_i = 32'h0000_00A5; alu_v_i = 1'b1;
    step();
    alu_v_i = 1'b0;
    chk("t2_not_yet", 64'(wb_o), 64'(0));
    step();
    chk("t2_wb", 64'(wb_o), 64'(1));
    chk("t2_rd", 64'(wb_r_o), 64'(3));
    chk("t2_data", 64'(result_o), 64'h00A5);
    step();
    chk("t2_one_cycle", 64'(wb_o), 64'(0));
    chk("t2_hold_rd", 64'(wb_r_o), 64'(3));
    chk("t2_hold_data", 64'(result_o), 64'h00A5);

    // Same-edge pushes after reset: ALU wins the first tie
    do_reset("t3");
    alu_rd_i = 5'd1; alu_data_i = 32'h0000_0111; alu_v_i = 1'b1;
    mem_rd_i = 5'd2; mem_data_i = 32'h0000_0222; mem_v_i = 1'b1;
    step();
    alu_v_i = 1'b0; mem_v_i = 1'b0;
    step();
    chk("t3_wb0", 64'(wb_o), 64'(1));
    chk("t3_rd0", 64'(wb_r_o), 64'(1));
    step();
    chk("t3_wb1", 64'(wb_o), 64'(1));
    chk("t3_rd1", 64'(wb_r_o), 64'(2));
    step();
    chk("t3_done", 64'(wb_o), 64'(0));
    chk("t3_idle", 64'(idle_o), 64'(1));

    // MEM backpressure: third push waits for a pop to free a slot
    do_reset("t4");
    alu_rd_i = 5'd4; alu_data_i = 32'h0000_0401; alu_v_i = 1'b1;
    mem_rd_i = 5'd6; mem_data_i = 32'h0000_0601; mem_v_i = 1'b1;
    cycle(a, m);
    chk("t4_rdy_e1", 64'(mem_rdy_o), 64'(1));
    alu_data_i = 32'h0000_0402;
    mem_data_i = 32'h0000_0602;
    cycle(a, m);
    alu_v_i = 1'b0;
    mem_data_i = 32'h0000_0603;
    chk("t4_acc_e2", 64'(mem_acc), 64'(2));
    chk("t4_full_e2", 64'(mem_rdy_o), 64'(0));
    chk("t4_wb_alu_first", 64'(wb_r_o), 64'(4));
    cycle(a, m);
    chk("t4_no_acc_when_full", 64'(mem_acc), 64'(2));
    chk("t4_rdy_after_pop", 64'(mem_rdy_o), 64'(1));
    chk("t4_wb_mem", 64'(wb_r_o), 64'(6));
    cycle(a, m);
    mem_v_i = 1'b0;
    chk("t4_acc_e4", 64'(mem_acc), 64'(3));
    drain("t4");

    // Both streaming 8 entries: strict alternation, 16 write-backs back to back
    do_reset("t5");
    n_a = 0; n_m = 0; k = 0;
    while (!(n_a == 8 && n_m == 8 && idle_o && wb_src.size() >= 16) && k < 100) begin
      alu_v_i = (n_a < 8);
      alu_rd_i = W_RD'(n_a);
      alu_data_i = W_OPR'(32'h0000_A000 + n_a);
      mem_v_i = (n_m < 8);
      mem_rd_i = W_RD'(n_m + 8);
      mem_data_i = W_OPR'(32'h0000_B000 + n_m);
      cycle(a, m);
      if (a) n_a++;
      if (m) n_m++;
      k++;
    end
    alu_v_i = 1'b0; mem_v_i = 1'b0;
    chk("t5_wb_count", 64'(wb_src.size()), 64'(16));
    alt_err = 0;
    for (int i = 1; i < wb_src.size(); i++)
      if (wb_src[i] == wb_src[i-1]) alt_err++;
    chk("t5_alternate", 64'(alt_err), 64'(0));
    if (wb_cyc.size() == 16)
      chk("t5_back_to_back", 64'(wb_cyc[15] - wb_cyc[0]), 64'(15));
    else
      chk("t5_back_to_back", 64'(wb_cyc.size()), 64'(16));
    chk("t5_alu_q_empty", 64'(alu_q.size()), 64'(0));
    chk("t5_mem_q_empty", 64'(mem_q.size()), 64'(0));

    // Reset mid-stream: queued entries are discarded, never written back
    do_reset("t1a");
    alu_v_i = 1'b1; mem_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_rd_i = W_RD'(20 + i); alu_data_i = W_OPR'(32'h0000_C000 + i);
      mem_rd_i = W_RD'(24 + i); mem_data_i = W_OPR'(32'h0000_D000 + i);
      step();
    end
    chk("t1_busy_before", 64'(idle_o), 64'(0));
    do_reset("t1");
    chk("t1_wb_r", 64'(wb_r_o), 64'(0));
    chk("t1_result", 64'(result_o), 64'(0));
    for (int i = 0; i < 6; i++) step();
    chk("t1_no_wb", 64'(wb_src.size()), 64'(0));
    chk("t1_idle_after", 64'(idle_o), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
